uart_rx: RTL and testbench

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 200 ++++++++++++++++++++
 tb/tb_uart_rx.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: 8-bit asynchronous serial receiver with a one-entry output buffer.
// Frame: start, 8 data bits LSB first, optional even parity, one stop bit.
// Build option: define UART_RX_PARITY_EN to receive and check an even parity bit.
module uart_rx #(
    parameter int CLK_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rxd,
    output logic [7:0] data,
    output logic       valid,
    input  logic       ready,
    output logic       frame_err,
    output logic       parity_err,
    output logic       overrun
);

    localparam int DATA_W = 8;
    localparam int CNT_W  = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLK_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        WAIT_HIGH
    } state_t;

    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [2:0]        idx, idx_n;
    logic [DATA_W-1:0] shreg, shreg_n;
    logic              rxd_m, rxd_s;
    logic              par_bad;
    logic              deliver, frame_err_n, parity_err_n;

    // Two-flop synchronizer; idles high so reset never looks like a start bit
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rxd_m <= 1'b1;
            rxd_s <= 1'b1;
        end else begin
            rxd_m <= rxd;
            rxd_s <= rxd_m;
        end
    end

`ifdef UART_RX_PARITY_EN
    logic par_bad_n;

    // Parity mismatch remembered from the parity bit until the stop bit decides
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            par_bad <= 1'b0;
        end else begin
            par_bad <= par_bad_n;
        end
    end
`else
    assign par_bad = 1'b0;
`endif

    // Receiver state, bit timer, bit index and shift register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
            shreg <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            idx   <= idx_n;
            shreg <= shreg_n;
        end
    end

    // Next-state logic; the bit timer wraps at every bit boundary
    always_comb begin
        state_n      = state;
        cnt_n        = cnt;
        idx_n        = idx;
        shreg_n      = shreg;
        deliver      = 1'b0;
        frame_err_n  = 1'b0;
        parity_err_n = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_bad_n    = par_bad;
`endif
        case (state)
            IDLE: begin
                cnt_n = '0;
                idx_n = '0;
`ifdef UART_RX_PARITY_EN
                par_bad_n = 1'b0;
`endif
                if (!rxd_s) begin
                    state_n = START;
                end
            end
            START: begin
                // Re-check the line half a bit in; a high line means a glitch
                if (cnt == CNT_HALF) begin
                    cnt_n   = '0;
                    idx_n   = '0;
                    state_n = rxd_s ? IDLE : DATA;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            DATA: begin
                if (cnt == CNT_LAST) begin
                    cnt_n   = '0;
                    shreg_n = {rxd_s, shreg[DATA_W-1:1]};
                    idx_n   = idx + 3'd1;
                    if (idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_n = PARITY;
`else
                        state_n = STOP;
`endif
                    end
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (cnt == CNT_LAST) begin
                    cnt_n     = '0;
                    par_bad_n = rxd_s ^ (^shreg);
                    state_n   = STOP;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
`endif
            STOP: begin
                if (cnt == CNT_LAST) begin
                    cnt_n = '0;
                    if (!rxd_s) begin
                        frame_err_n  = 1'b1;
                        parity_err_n = par_bad;
                        state_n      = WAIT_HIGH;
                    end else if (par_bad) begin
                        parity_err_n = 1'b1;
                        state_n      = IDLE;
                    end else begin
                        deliver = 1'b1;
                        state_n = IDLE;
                    end
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            WAIT_HIGH: begin
                // A held-low line (break) must not be mistaken for a new start bit
                cnt_n = '0;
                if (rxd_s) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // Output buffer with valid/ready handshake and one-cycle status pulses
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            data       <= '0;
            valid      <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_err  <= frame_err_n;
            parity_err <= parity_err_n;
            overrun    <= 1'b0;
            if (deliver) begin
                if (!valid || ready) begin
                    data  <= shreg;
                    valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized and directed serial frames for uart_rx; a scoreboard
// queue of expected output events is drained by an independent monitor.
`timescale 1ns/1ps
module tb_uart_rx;

    localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
    localparam int NBITS  = 11;
    localparam bit PAR_EN = 1'b1;
`else
    localparam int NBITS  = 10;
    localparam bit PAR_EN = 1'b0;
`endif
    localparam int EV_BYTE  = 0;
    localparam int EV_FRAME = 1;
    localparam int EV_PAR   = 2;
    localparam int EV_OVR   = 3;

    typedef struct {
        int         kind;
        logic [7:0] data;
        int         deadline;
    } ev_t;

    ev_t exp_q[$];

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       rxd = 1'b1;
    logic       ready = 1'b0;
    logic [7:0] data;
    logic       valid, frame_err, parity_err, overrun;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    bit rand_ready = 1'b0;

    logic       v_q = 1'b0;
    logic       r_q = 1'b0;
    logic       rs_q = 1'b0;
    logic [7:0] d_q = 8'h00;

    uart_rx #(.CLK_PER_BIT(CPB)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .rxd        (rxd),
        .data       (data),
        .valid      (valid),
        .ready      (ready),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .overrun    (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic got_event(input int kind, input logic [7:0] d);
        ev_t e;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_event: got kind %0d data %02h at cycle %0d, want no event",
                     kind, d, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || (kind == EV_BYTE && e.data !== d) || cyc > e.deadline) begin
                n_err++;
                $display("FAIL event: got kind %0d data %02h at cycle %0d, want kind %0d data %02h by cycle %0d",
                         kind, d, cyc, e.kind, e.data, e.deadline);
            end
        end
    endtask

    // Monitor: samples on the falling edge, matches every output event to the queue
    initial begin
        forever begin
            @(negedge clk);
            if (rs_q) begin
                if (frame_err) got_event(EV_FRAME, 8'h00);
                if (parity_err) got_event(EV_PAR, 8'h00);
                if (valid && !v_q) got_event(EV_BYTE, data);
                if (overrun) got_event(EV_OVR, 8'h00);
                if (v_q && r_q) begin
                    check("valid_fall_after_transfer", 32'(valid), 32'd0);
                end else if (v_q) begin
                    check("valid_hold", 32'(valid), 32'd1);
                    check("data_hold", 32'(data), 32'(d_q));
                end
            end
            v_q  = valid;
            r_q  = ready;
            d_q  = data;
            rs_q = reset_n;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_ready) ready = 1'($urandom_range(0, 1));
    endtask

    task automatic idle(input int n);
        rxd = 1'b1;
        repeat (n) tick();
    endtask

    task automatic push(input int kind, input logic [7:0] d, input int deadline);
        ev_t e;
        e.kind = kind;
        e.data = d;
        e.deadline = deadline;
        exp_q.push_back(e);
    endtask

    // Reference model: outcome of a frame follows from its stop bit, parity and buffer state
    task automatic send_frame(input logic [7:0] b, input bit stop_b, input bit par_bad, input bit exp_ovr);
        logic [10:0] fr;
        int dl;
        dl = cyc + (NBITS - 1) * CPB + CPB / 2 + 17;
        if (!stop_b) begin
            push(EV_FRAME, 8'h00, dl);
            if (PAR_EN && par_bad) push(EV_PAR, 8'h00, dl);
        end else if (PAR_EN && par_bad) begin
            push(EV_PAR, 8'h00, dl);
        end else if (exp_ovr) begin
            push(EV_OVR, 8'h00, dl);
        end else begin
            push(EV_BYTE, b, dl);
        end
        fr = '1;
        fr[0] = 1'b0;
        fr[8:1] = b;
        if (NBITS == 11) fr[9] = (^b) ^ par_bad;
        fr[NBITS-1] = stop_b;
        for (int i = 0; i < NBITS; i++) begin
            rxd = fr[i];
            repeat (CPB) tick();
        end
    endtask

    initial begin
        reset_n = 1'b0;
        rxd = 1'b1;
        ready = 1'b0;
        repeat (3) tick();
        check("reset_data", 32'(data), 32'h00);
        check("reset_valid", 32'(valid), 32'd0);
        check("reset_frame_err", 32'(frame_err), 32'd0);
        check("reset_parity_err", 32'(parity_err), 32'd0);
        check("reset_overrun", 32'(overrun), 32'd0);
        reset_n = 1'b1;
        idle(20);

        // Clean frame, consumer always ready
        ready = 1'b1;
        send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
        idle(20);

        // Bad stop bit followed by a 40-cycle break, then a good frame
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        rxd = 1'b0;
        repeat (40) tick();
        check("break_no_valid", 32'(valid), 32'd0);
        idle(30);
        send_frame(8'h11, 1'b1, 1'b0, 1'b0);
        idle(20);
        check("after_break_data", 32'(data), 32'h11);

        // Short low glitch must be rejected
        rxd = 1'b0;
        repeat (4) tick();
        idle(60);

        // Overrun: consumer stalled across two deliveries
        ready = 1'b0;
        send_frame(8'h01, 1'b1, 1'b0, 1'b0);
        idle(20);
        send_frame(8'h02, 1'b1, 1'b0, 1'b1);
        idle(20);
        check("overrun_keeps_old", 32'(data), 32'h01);
        ready = 1'b1;
        tick();
        ready = 1'b0;
        tick();
        check("valid_after_single_ready", 32'(valid), 32'd0);
        check("dropped_byte_absent", 32'(data == 8'h02), 32'd0);
        ready = 1'b1;
        idle(10);

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b1, 1'b0);
        idle(20);
        check("parity_bad_no_valid", 32'(valid), 32'd0);
        send_frame(8'h07, 1'b1, 1'b0, 1'b0);
        idle(20);
        check("parity_ok_data", 32'(data), 32'h07);
`endif

        // Reset in the middle of data bit 3 of 0x08
        rxd = 1'b0;
        repeat (CPB) tick();
        repeat (3 * CPB) tick();
        rxd = 1'b1;
        repeat (CPB / 2) tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check("midreset_data", 32'(data), 32'h00);
        check("midreset_valid", 32'(valid), 32'd0);
        check("midreset_flags", 32'({frame_err, parity_err, overrun}), 32'd0);
        idle(40);
        send_frame(8'h5A, 1'b1, 1'b0, 1'b0);
        idle(20);
        check("after_reset_data", 32'(data), 32'h5A);

        // Randomized frames with random consumer back-pressure
        rand_ready = 1'b1;
        for (int k = 0; k < 14; k++) begin
            logic [7:0] b;
            bit         sb;
            bit         pb;
            b  = 8'($urandom);
            sb = ($urandom_range(0, 4) != 0);
            pb = PAR_EN ? ($urandom_range(0, 3) == 0) : 1'b0;
            send_frame(b, sb, pb, 1'b0);
            if (!sb) begin
                rxd = 1'b0;
                repeat ($urandom_range(0, 30)) tick();
            end
            idle($urandom_range(20, 60));
        end
        rand_ready = 1'b0;
        ready = 1'b1;
        idle(100);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
